// File: rtl/stopwatch_lap.sv
// Lab-board BCD stopwatch with lap (split) display, sticky overflow and
// debounced-by-synchroniser start/stop and clear/lap pushbuttons.
module stopwatch_lap #(
  parameter int TICK_DIV = 5000000,
  parameter int DIGITS   = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                S1,
  input  logic                S2,
  output logic [7*DIGITS-1:0] hex,
  output logic                running,
  output logic                lap_active,
  output logic                overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  state_t state, state_nx;

  logic s1_p0, s1_p1, s1_p2;
  logic s2_p0, s2_p1, s2_p2;
  logic press1, press2;
  logic clear, capture;

  logic [PW-1:0]         presc;
  logic                  tick;
  logic [4*DIGITS-1:0]   count, count_inc, lap_q, shown;
  logic                  carry;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Button stage: two synchroniser flops (_p0,_p1) then previous-value flop (_p2)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_p0 <= 1'b1; s1_p1 <= 1'b1; s1_p2 <= 1'b1;
      s2_p0 <= 1'b1; s2_p1 <= 1'b1; s2_p2 <= 1'b1;
    end else begin
      s1_p0 <= S1; s1_p1 <= s1_p0; s1_p2 <= s1_p1;
      s2_p0 <= S2; s2_p1 <= s2_p0; s2_p2 <= s2_p1;
    end
  end

  assign press1 = s1_p2 & ~s1_p1;
  assign press2 = s2_p2 & ~s2_p1;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // S1 is checked first in every state, so a same-cycle S2 pulse is dropped.
  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: if (press1) state_nx = RUN;
      RUN: begin
        if (press1) state_nx = STOP;
        else if (press2) begin
          state_nx = LAP;
          capture  = 1'b1;
        end
      end
      LAP: begin
        if (press1)      state_nx = STOP;
        else if (press2) state_nx = RUN;
      end
      STOP: begin
        if (press1) state_nx = RUN;
        else if (press2) begin
          state_nx = IDLE;
          clear    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign running    = (state == RUN) || (state == LAP);
  assign lap_active = (state == LAP);
  assign tick       = running && (presc == PW'(TICK_DIV - 1));

  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Timebase and count: tick and state change may share an edge; both apply.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc    <= '0;
      count    <= '0;
      lap_q    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      presc    <= '0;
      count    <= '0;
      lap_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (running) presc <= tick ? '0 : presc + PW'(1);
      if (capture) lap_q <= count;
      if (tick) begin
        count <= count_inc;
        if (carry) overflow <= 1'b1;
      end
    end
  end

  assign shown = lap_active ? lap_q : count;

  always_comb begin
    hex = '1;
    for (int i = 0; i < DIGITS; i++) hex[7*i +: 7] = seg7(shown[4*i +: 4]);
  end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap with TICK_DIV=2, DIGITS=3: one tick per
// two clocks while running, so expected counts are worked out by edge number.
module tb_stopwatch_lap;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        S1 = 1'b1;
  logic        S2 = 1'b1;
  logic [20:0] hex;
  logic        running, lap_active, overflow;

  int tests  = 0;
  int failed = 0;

  stopwatch_lap #(.TICK_DIV(2), .DIGITS(3)) dut (
    .clk(clk), .resetn(resetn), .S1(S1), .S2(S2),
    .hex(hex), .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  always #10 clk = ~clk;

  function automatic logic [20:0] hx(input int d2, input int d1, input int d0);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return {tbl[d2], tbl[d1], tbl[d0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // State update lands on the 3rd edge; one extra edge lets the synchroniser see the release.
  task automatic press(input bit b1, input bit b2);
    @(negedge clk);
    if (b1) S1 = 1'b0;
    if (b2) S2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    S1 = 1'b1;
    S2 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset values, S2 ignored in IDLE
    do_reset();
    chk("reset_hex", hex, hx(0, 0, 0));
    chk("reset_running", running, 0);
    chk("reset_lap", lap_active, 0);
    chk("reset_ovf", overflow, 0);
    press(0, 1);
    chk("idle_s2_hex", hex, hx(0, 0, 0));
    chk("idle_s2_running", running, 0);

    // 2: start, 40 edges after RUN entry -> 020
    press(1, 0);
    chk("start_running", running, 1);
    cyc(39);
    chk("count_020", hex, hx(0, 2, 0));

    // 3: lap at 013, live count keeps going, lap release shows live
    do_reset();
    chk("reset2_hex", hex, hx(0, 0, 0));
    press(1, 0);
    cyc(23);
    press(0, 1);
    chk("lap_active", lap_active, 1);
    chk("lap_hex_013", hex, hx(0, 1, 3));
    cyc(20);
    chk("lap_hold_013", hex, hx(0, 1, 3));
    chk("lap_running", running, 1);
    press(0, 1);
    chk("unlap_active", lap_active, 0);
    chk("unlap_live_026", hex, hx(0, 2, 6));

    // 4: stop, hold, resume without lost/extra tick, then clear
    press(1, 0);
    chk("stop_running", running, 0);
    chk("stop_hex_027", hex, hx(0, 2, 7));
    cyc(30);
    chk("stop_hold_027", hex, hx(0, 2, 7));
    press(1, 0);
    chk("resume_running", running, 1);
    chk("resume_028", hex, hx(0, 2, 8));
    cyc(2);
    chk("resume_029", hex, hx(0, 2, 9));
    press(1, 0);
    chk("stop2_030", hex, hx(0, 3, 0));
    press(0, 1);
    chk("clear_hex", hex, hx(0, 0, 0));
    chk("clear_running", running, 0);
    chk("clear_ovf", overflow, 0);

    // 5: wrap 999 -> 000 sets sticky overflow
    press(1, 0);
    cyc(1989);
    chk("cnt_995", hex, hx(9, 9, 5));
    chk("ovf_before", overflow, 0);
    cyc(9);
    chk("cnt_999", hex, hx(9, 9, 9));
    chk("ovf_at_999", overflow, 0);
    cyc(1);
    chk("wrap_000", hex, hx(0, 0, 0));
    chk("wrap_ovf", overflow, 1);
    cyc(2);
    chk("after_wrap_001", hex, hx(0, 0, 1));
    press(1, 0);
    chk("ovf_in_stop", overflow, 1);
    chk("stop_002", hex, hx(0, 0, 2));
    press(0, 1);
    chk("ovf_cleared", overflow, 0);
    chk("clear2_hex", hex, hx(0, 0, 0));

    // 6: simultaneous S1+S2 on a tick edge -> STOP only, increment kept
    press(1, 0);
    press(1, 1);
    chk("both_running", running, 0);
    chk("both_lap", lap_active, 0);
    chk("both_hex_002", hex, hx(0, 0, 2));
    // RUN->LAP on a tick edge captures the pre-increment count
    press(1, 0);
    press(0, 1);
    chk("lap_tick_active", lap_active, 1);
    chk("lap_tick_003", hex, hx(0, 0, 3));
    // reset while in LAP
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_lap_hex", hex, hx(0, 0, 0));
    chk("rst_lap_running", running, 0);
    chk("rst_lap_lap", lap_active, 0);
    chk("rst_lap_ovf", overflow, 0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(4);
    chk("post_rst_hex", hex, hx(0, 0, 0));
    chk("post_rst_running", running, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
- Parametrised successor to the lab stopwatch. Decimal BCD counter of DIGITS digits; digit 0 is tenths of a second.
- Start/stop and clear/lap are driven by two active-low pushbuttons.
- Adds a lap (split) mode: the display freezes while counting continues.
- Adds a sticky overflow flag on wrap-around.
- Drives DIGITS active-low seven-segment displays on the lab board.

Parameters:
- TICK_DIV, 5000000, clock cycles per tenth-second tick (50 MHz board clock); minimum 2.
- DIGITS, 3, number of BCD digits and seven-segment displays; minimum 2.

Ports:
- clk  in  1  system clock, rising-edge.
- resetn  in  1  synchronous active-low reset; one clock, all state sampled on rising edge of clk.
- S1  in  1  start/stop pushbutton, active-low, asynchronous to clk.
- S2  in  1  clear/lap pushbutton, active-low, asynchronous to clk.
- hex  out  7*DIGITS  segment patterns. hex[7*i+6:7*i] = digit i, bit order {g,f,e,d,c,b,a}, active-low.
- running  out  1  1 in RUN or LAP.
- lap_active  out  1  1 in LAP.
- overflow  out  1  sticky; set when the count wraps from all-9s to 0.

Behaviour:
- Reset (resetn=0 at a rising edge):
  - state=IDLE; count, lap register and prescaler are 0; overflow=0.
  - Synchroniser and edge-detect flops are set to 1 (released).
  - All hex digits show "0" (7'b1000000).
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a previous-value flop.
  - press = prev & ~sync2: a single-cycle pulse per falling edge. Holding a button generates one press only.
  - The state update takes effect at the 3rd rising edge after the button is first sampled low.
- Simultaneous S1 and S2 press pulses in the same cycle: S1 wins; S2 is discarded.
- States and transitions:
  - IDLE: S1 -> RUN; S2 ignored.
  - RUN: S1 -> STOP; S2 -> LAP, and lap register <= count on that edge.
  - LAP: S1 -> STOP (display returns to live count); S2 -> RUN (display live).
  - STOP: S1 -> RUN, resuming from the held count and prescaler; S2 -> IDLE, clearing count, prescaler, lap register and overflow.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN or LAP, and holds otherwise.
  - tick=1 for the one cycle in which prescaler==TICK_DIV-1; the prescaler returns to 0 on the next edge.
  - Width = clog2(TICK_DIV).
- Count:
  - On the tick edge, digit 0 increments. A digit at 9 becomes 0 and carries into the next digit.
  - All digits 9 -> all 0 and overflow <= 1. overflow stays 1 until reset or a STOP->IDLE clear.
  - Counting continues after a wrap.
- Same-edge tick and press: the count update and the state update both apply on that edge.
  - RUN->STOP on a tick edge: the increment is still taken.
  - RUN->LAP on a tick edge: the lap register captures the pre-increment count.
- Display:
  - The value shown is the lap register in LAP, otherwise the live count.
  - hex is combinational from the shown value.
  - Decode 0-9: 40,79,24,30,19,12,02,78,00,10 (hex, gfedcba active-low). Codes 10-15 are unreachable; show 7'h7F (blank).
- Reset mid-operation: reset overrides any state or pending press. A press pulse already in the pipeline is lost.

Test Plan:
- Bench configuration for all scenarios: TICK_DIV=2, DIGITS=3, clk period 20 ns.
1. Reset -> hex = {40,40,40}, running=0, overflow=0. S2 press in IDLE -> no change.
2. S1 press -> running=1 at the 3rd edge. After 20 ticks (40 cycles) the count is 020: hex[6:0]=40, hex[13:7]=24, hex[20:14]=40.
3. In RUN at count 013, S2 press -> lap_active=1 and display holds 013 while the internal count advances. After 10 more ticks, S2 press -> display jumps to the live count (023 + pipeline ticks), lap_active=0.
4. S1 press in RUN -> STOP; hold 30 cycles, count unchanged. S1 press -> resumes from the same value with no lost or extra tick. S1 then S2 press -> IDLE, display 000, overflow=0.
5. Run from 995 for 5 ticks -> count 000, overflow=1. Continues to 001. overflow stays 1 until STOP->IDLE clear.
6. S1 and S2 falling in the same cycle while in RUN -> STOP only, lap_active stays 0. Assert resetn=0 while in LAP -> IDLE, all outputs at reset values the following cycle.
